// File: rtl/prio_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : prio_pkg
//  Purpose  : Shared constants and index helpers for the priority
//             encoder / arbiter slice.
//  Contents : MODE_FIXED / MODE_RR mode encodings,
//             wrap_dec() - decrement modulo n (0 wraps to n-1).
//  Revision : 1.0 - initial release
// ============================================================================
package prio_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Decrement modulo n; works for any n >= 2, not only powers of two.
    function automatic int wrap_dec(input int v, input int n);
        return (v == 0) ? (n - 1) : (v - 1);
    endfunction

endpackage : prio_pkg
`default_nettype wire

// File: rtl/prio_search.sv
`default_nettype none
// ============================================================================
//  Module   : prio_search
//  Purpose  : Combinational circular priority search. The request vector
//             is rotated so that 'start' lands on the MSB, the highest set
//             bit is found, and its position is mapped back to a requester
//             index. Search order: start, start-1, ..., 0, N-1, ..., start+1.
//  Ports    : req   [N-1:0]  request vector
//             start [W-1:0]  highest-priority index for this search
//             found          any request present
//             idx   [W-1:0]  winning requester index (0 when !found)
//  Revision : 1.0 - initial release
// ============================================================================
module prio_search #(
    parameter int N = 16
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] start,
    output logic                 found,
    output logic [$clog2(N)-1:0] idx
);

    localparam int W = $clog2(N);

    // Requester index that sits at rotated position j: position N-1 is
    // 'start' itself, position j is start+j+1 modulo N.
    function automatic int src_of(input int st, input int j);
        int s;
        s = st + j + 1;
        if (s >= N) begin
            s = s - N;
        end
        return s;
    endfunction

    logic [N-1:0] rot;
    int           hi;

    always_comb begin
        rot = '0;
        for (int j = 0; j < N; j++) begin
            rot[j] = req[W'(src_of(int'(start), j))];
        end
    end

    always_comb begin
        hi = 0;
        for (int j = 0; j < N; j++) begin
            if (rot[j]) begin
                hi = j;
            end
        end
    end

    assign found = |rot;
    assign idx   = found ? W'(src_of(int'(start), hi)) : '0;

endmodule : prio_search
`default_nettype wire

// File: rtl/prio_enc_arb.sv
`default_nettype none
// ============================================================================
//  Module   : prio_enc_arb
//  Purpose  : Registered N-input priority encoder / arbiter with fixed
//             priority or round-robin selection and a valid/ready output
//             register that holds each grant until it is accepted.
//  Ports    : clk, rst (async, active high)
//             req [N-1:0]          request vector
//             mode                 0 = fixed priority, 1 = round-robin
//             out_ready            consumer accepts current grant
//             out_valid            grant register holds a grant
//             out_idx [W-1:0]      granted index
//             out_onehot [N-1:0]   one-hot of out_idx, zero when !out_valid
//  Revision : 1.0 - initial release
// ============================================================================
module prio_enc_arb
    import prio_pkg::*;
#(
    parameter int N = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic                 mode,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [$clog2(N)-1:0] out_idx,
    output logic [N-1:0]         out_onehot
);

    localparam int W = $clog2(N);

    logic         load;
    logic [W-1:0] last;
    logic [W-1:0] start;
    logic         win_found;
    logic [W-1:0] win_idx;

    // Register accepts new content when empty or when the held grant is
    // being consumed on this edge (back-to-back grants, no bubble).
    assign load = !out_valid || out_ready;

    // Round-robin begins just below the last round-robin winner; fixed
    // priority always begins at the top index.
    assign start = (mode == MODE_RR) ? W'(wrap_dec(int'(last), N)) : W'(N - 1);

    prio_search #(
        .N (N)
    ) u_search (
        .req   (req),
        .start (start),
        .found (win_found),
        .idx   (win_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_idx    <= '0;
            out_onehot <= '0;
            last       <= '0;
        end else if (load) begin
            if (win_found) begin
                out_valid  <= 1'b1;
                out_idx    <= win_idx;
                out_onehot <= {{(N-1){1'b0}}, 1'b1} << win_idx;
                // Fixed-mode grants leave 'last' alone so round-robin
                // resumes where it stopped.
                if (mode == MODE_RR) begin
                    last <= win_idx;
                end
            end else begin
                out_valid  <= 1'b0;
                out_idx    <= '0;
                out_onehot <= '0;
            end
        end
    end

endmodule : prio_enc_arb
`default_nettype wire

// File: tb/tb_prio_enc_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prio_enc_arb
//  Purpose  : Self-checking bench for prio_enc_arb (N=16 and N=5 instances).
//             A behavioural grant model is compared against both DUTs on
//             every falling edge; directed sequences add literal checks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_prio_enc_arb;

    logic        clk = 1'b0;
    logic        rst;

    logic [15:0] req_a;
    logic        mode_a;
    logic        ready_a;
    logic        valid_a;
    logic [3:0]  idx_a;
    logic [15:0] onehot_a;

    logic [4:0]  req_b;
    logic        mode_b;
    logic        ready_b;
    logic        valid_b;
    logic [2:0]  idx_b;
    logic [4:0]  onehot_b;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    prio_enc_arb #(.N(16)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .req        (req_a),
        .mode       (mode_a),
        .out_ready  (ready_a),
        .out_valid  (valid_a),
        .out_idx    (idx_a),
        .out_onehot (onehot_a)
    );

    prio_enc_arb #(.N(5)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .req        (req_b),
        .mode       (mode_b),
        .out_ready  (ready_b),
        .out_valid  (valid_b),
        .out_idx    (idx_b),
        .out_onehot (onehot_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Winner straight from the arbitration rule: walk candidates in
    // priority order and take the first requester present; -1 if none.
    function automatic int model_win(input logic [15:0] r, input int n, input bit rr, input int lst);
        for (int step = 0; step < n; step++) begin
            int cand;
            cand = rr ? (((lst - 1 - step) % n) + n) % n : (n - 1 - step);
            if (r[cand]) return cand;
        end
        return -1;
    endfunction

    // ---------------- behavioural model ----------------
    bit m_valid_a, m_valid_b;
    int m_idx_a, m_idx_b, m_last_a, m_last_b;
    int w_a, w_b;

    always_comb w_a = model_win(req_a, 16, mode_a, m_last_a);
    always_comb w_b = model_win({11'b0, req_b}, 5, mode_b, m_last_b);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid_a <= 1'b0; m_idx_a <= 0; m_last_a <= 0;
            m_valid_b <= 1'b0; m_idx_b <= 0; m_last_b <= 0;
        end else begin
            if (!m_valid_a || ready_a) begin
                m_valid_a <= (w_a >= 0);
                m_idx_a   <= (w_a >= 0) ? w_a : 0;
                if (w_a >= 0 && mode_a) m_last_a <= w_a;
            end
            if (!m_valid_b || ready_b) begin
                m_valid_b <= (w_b >= 0);
                m_idx_b   <= (w_b >= 0) ? w_b : 0;
                if (w_b >= 0 && mode_b) m_last_b <= w_b;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_a_valid",  32'(valid_a),  32'(m_valid_a));
            chk("model_a_idx",    32'(idx_a),    32'(m_idx_a));
            chk("model_a_onehot", 32'(onehot_a), m_valid_a ? (32'd1 << m_idx_a) : 32'd0);
            chk("model_b_valid",  32'(valid_b),  32'(m_valid_b));
            chk("model_b_idx",    32'(idx_b),    32'(m_idx_b));
            chk("model_b_onehot", 32'(onehot_b), m_valid_b ? (32'd1 << m_idx_b) : 32'd0);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_a(input string tag, input bit v, input int idx);
        chk({tag, "_valid"},  32'(valid_a),  32'(v));
        chk({tag, "_idx"},    32'(idx_a),    32'(idx));
        chk({tag, "_onehot"}, 32'(onehot_a), v ? (32'd1 << idx) : 32'd0);
    endtask

    task automatic expect_b(input string tag, input bit v, input int idx);
        chk({tag, "_valid"},  32'(valid_b),  32'(v));
        chk({tag, "_idx"},    32'(idx_b),    32'(idx));
        chk({tag, "_onehot"}, 32'(onehot_b), v ? (32'd1 << idx) : 32'd0);
    endtask

    initial begin
        rst = 1'b0;
        req_a = '0; mode_a = 1'b0; ready_a = 1'b0;
        req_b = '0; mode_b = 1'b0; ready_b = 1'b0;
        #1 rst = 1'b1;
        #1;
        expect_a("reset_a", 1'b0, 0);
        expect_b("reset_b", 1'b0, 0);
        #19 rst = 1'b0;
        chk_en = 1'b1;

        // 1: fixed priority, top bit always wins over bit 0
        mode_a = 1'b0; req_a = 16'h8001; ready_a = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            expect_a("fixed_8001", 1'b1, 15);
        end

        // 2: round-robin over all requesters, no bubbles
        mode_a = 1'b1; req_a = 16'hFFFF;
        for (int i = 0; i < 18; i++) begin
            tick();
            expect_a("rr_ffff", 1'b1, (15 - i) & 15);
        end

        // 3: round-robin between 4 and 1, fixed detour, resume
        req_a = 16'h0012;
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_a("rr_0012", 1'b1, (i % 2 == 0) ? 4 : 1);
        end
        mode_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_a("fixed_0012", 1'b1, 4);
        end
        mode_a = 1'b1;
        tick();
        expect_a("rr_resume", 1'b1, 1);

        // 4: backpressure holds grant while requests change
        mode_a = 1'b0; req_a = 16'h0000; ready_a = 1'b1;
        tick();
        expect_a("drain", 1'b0, 0);
        ready_a = 1'b0; req_a = 16'h0004;
        tick();
        expect_a("bp_load", 1'b1, 2);
        req_a = 16'h8000;
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_a("bp_hold", 1'b1, 2);
        end
        ready_a = 1'b1;
        tick();
        expect_a("bp_release", 1'b1, 15);

        // 5: empty request clears the register, then bit 0 alone
        req_a = 16'h0000;
        tick();
        expect_a("empty", 1'b0, 0);
        req_a = 16'h0001;
        tick();
        expect_a("bit0", 1'b1, 0);

        // 6: asynchronous reset mid-stream
        mode_a = 1'b1; req_a = 16'h0080;
        tick();
        expect_a("pre_reset", 1'b1, 7);
        #2 rst = 1'b1;
        #1;
        expect_a("async_reset", 1'b0, 0);
        #3 rst = 1'b0;
        req_a = 16'hFFFF;
        tick();
        expect_a("post_reset", 1'b1, 15);

        // 7: non-power-of-two wrap, N=5
        mode_b = 1'b1; req_b = 5'b10001; ready_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_b("rr_n5", 1'b1, (i % 2 == 0) ? 4 : 0);
        end

        tick();
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_prio_enc_arb
`default_nettype wire
